// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one single-port 32-bit SRAM between the fetch
// requester and the load/store requester. Each access walks
// IDLE -> ISSUE -> (WAIT) -> DONE, and the stall outputs feed the hazard unit.
//
// state | meaning
// IDLE  | choose a requester, latch its address/enables/data
// ISSUE | strobe the SRAM for one cycle with the latched access
// WAIT  | count down the read latency, capture read data on the last cycle
// DONE  | one-cycle valid pulse to the owner of the access
module sram_port_arbiter #(
  parameter int unsigned RD_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic [31:0] inst_rdata,
  output logic        inst_valid,
  output logic        inst_stall,
  input  logic        data_req,
  input  logic [3:0]  data_wen,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_valid,
  output logic        data_stall,
  output logic        sram_en,
  output logic [3:0]  sram_wen,
  output logic [31:0] sram_addr,
  output logic [31:0] sram_wdata,
  input  logic [31:0] sram_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;

  localparam logic [2:0] RD_LAT_C = 3'(RD_LAT);

  state_e      state_q, state_d;
  logic        owner_data_q, owner_data_d;
  logic        prio_inst_q, prio_inst_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        sram_en_q, sram_en_d;
  logic [3:0]  sram_wen_q, sram_wen_d;
  logic [31:0] sram_addr_q, sram_addr_d;
  logic [31:0] sram_wdata_q, sram_wdata_d;
  logic [31:0] inst_rdata_q, inst_rdata_d;
  logic [31:0] data_rdata_q, data_rdata_d;
  logic        inst_valid_q, inst_valid_d;
  logic        data_valid_q, data_valid_d;
  logic        grant_data;

  // Next-state and registered-output computation for the access sequencer.
  always_comb begin
    state_d      = state_q;
    owner_data_d = owner_data_q;
    prio_inst_d  = prio_inst_q;
    cnt_d        = cnt_q;
    sram_en_d    = 1'b0;
    sram_wen_d   = sram_wen_q;
    sram_addr_d  = sram_addr_q;
    sram_wdata_d = sram_wdata_q;
    inst_rdata_d = inst_rdata_q;
    data_rdata_d = data_rdata_q;
    inst_valid_d = 1'b0;
    data_valid_d = 1'b0;
    grant_data   = data_req && !(inst_req && prio_inst_q);
    case (state_q)
      IDLE: begin
        if (inst_req || data_req) begin
          owner_data_d = grant_data;
          sram_en_d    = 1'b1;
          state_d      = ISSUE;
          if (grant_data) begin
            sram_wen_d   = data_wen;
            sram_addr_d  = data_addr;
            sram_wdata_d = data_wdata;
            prio_inst_d  = inst_req;
          end else begin
            sram_wen_d   = 4'b0000;
            sram_addr_d  = inst_addr;
            sram_wdata_d = 32'h0;
            prio_inst_d  = 1'b0;
          end
        end
      end
      ISSUE: begin
        // Write enables only accompany the strobe cycle.
        sram_wen_d = 4'b0000;
        if (sram_wen_q == 4'b0000) begin
          cnt_d   = RD_LAT_C;
          state_d = WAIT;
        end else begin
          data_rdata_d = 32'h0;
          data_valid_d = 1'b1;
          state_d      = DONE;
        end
      end
      WAIT: begin
        if (cnt_q == 3'd1) begin
          cnt_d   = 3'd0;
          state_d = DONE;
          if (owner_data_q) begin
            data_rdata_d = sram_rdata;
            data_valid_d = 1'b1;
          end else begin
            inst_rdata_d = sram_rdata;
            inst_valid_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_data_q <= 1'b0;
      prio_inst_q  <= 1'b0;
      cnt_q        <= 3'd0;
      sram_en_q    <= 1'b0;
      sram_wen_q   <= 4'b0000;
      sram_addr_q  <= 32'h0;
      sram_wdata_q <= 32'h0;
      inst_rdata_q <= 32'h0;
      data_rdata_q <= 32'h0;
      inst_valid_q <= 1'b0;
      data_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_data_q <= owner_data_d;
      prio_inst_q  <= prio_inst_d;
      cnt_q        <= cnt_d;
      sram_en_q    <= sram_en_d;
      sram_wen_q   <= sram_wen_d;
      sram_addr_q  <= sram_addr_d;
      sram_wdata_q <= sram_wdata_d;
      inst_rdata_q <= inst_rdata_d;
      data_rdata_q <= data_rdata_d;
      inst_valid_q <= inst_valid_d;
      data_valid_q <= data_valid_d;
    end
  end

  assign sram_en    = sram_en_q;
  assign sram_wen   = sram_wen_q;
  assign sram_addr  = sram_addr_q;
  assign sram_wdata = sram_wdata_q;
  assign inst_rdata = inst_rdata_q;
  assign data_rdata = data_rdata_q;
  assign inst_valid = inst_valid_q;
  assign data_valid = data_valid_q;
  assign inst_stall = inst_req & ~inst_valid_q;
  assign data_stall = data_req & ~data_valid_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter: one instance at RD_LAT=1 and one at
// RD_LAT=3 share rst and the address/data/SRAM-read inputs, each with its own
// request lines. Inputs change 1 time unit after the rising edge and outputs
// are compared 2 units later, well before the falling edge.
module tb_sram_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req, data_req, inst_req3, data_req3;
  logic [31:0] inst_addr, data_addr, data_wdata, sram_rdata;
  logic [3:0]  data_wen;

  logic [31:0] inst_rdata, data_rdata, sram_addr, sram_wdata;
  logic        inst_valid, inst_stall, data_valid, data_stall, sram_en;
  logic [3:0]  sram_wen;

  logic [31:0] inst_rdata3, data_rdata3, sram_addr3, sram_wdata3;
  logic        inst_valid3, inst_stall3, data_valid3, data_stall3, sram_en3;
  logic [3:0]  sram_wen3;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sram_port_arbiter #(.RD_LAT(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_rdata(inst_rdata),
    .inst_valid(inst_valid), .inst_stall(inst_stall),
    .data_req(data_req), .data_wen(data_wen), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_rdata(data_rdata), .data_valid(data_valid),
    .data_stall(data_stall),
    .sram_en(sram_en), .sram_wen(sram_wen), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  sram_port_arbiter #(.RD_LAT(3)) u_dut3 (
    .clk(clk), .rst(rst),
    .inst_req(inst_req3), .inst_addr(inst_addr), .inst_rdata(inst_rdata3),
    .inst_valid(inst_valid3), .inst_stall(inst_stall3),
    .data_req(data_req3), .data_wen(data_wen), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_rdata(data_rdata3), .data_valid(data_valid3),
    .data_stall(data_stall3),
    .sram_en(sram_en3), .sram_wen(sram_wen3), .sram_addr(sram_addr3),
    .sram_wdata(sram_wdata3), .sram_rdata(sram_rdata)
  );

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    inst_req = 1'b0; data_req = 1'b0; inst_req3 = 1'b0; data_req3 = 1'b0;
    inst_addr = 32'h0; data_addr = 32'h0; data_wdata = 32'h0;
    data_wen = 4'b0000; sram_rdata = 32'h0;
    next_cycle();
    next_cycle();
    rst = 1'b0;
    settle();
    chk("rst_sram_en", {31'h0, sram_en}, 32'h0);
    chk("rst_sram_addr", sram_addr, 32'h0);
    chk("rst_valids", {30'h0, inst_valid, data_valid}, 32'h0);
    chk("rst_rdata", inst_rdata | data_rdata, 32'h0);

    // ---- single fetch, RD_LAT=1 ----
    next_cycle();                                    // cycle 0
    inst_req = 1'b1; inst_addr = 32'hBFC0_0000;
    settle();
    chk("f1_c0_stall", {31'h0, inst_stall}, 32'h1);
    chk("f1_c0_en", {31'h0, sram_en}, 32'h0);
    next_cycle();                                    // cycle 1: ISSUE
    sram_rdata = 32'hDEAD_DEAD;
    settle();
    chk("f1_c1_en", {31'h0, sram_en}, 32'h1);
    chk("f1_c1_addr", sram_addr, 32'hBFC0_0000);
    chk("f1_c1_wen", {28'h0, sram_wen}, 32'h0);
    chk("f1_c1_stall", {31'h0, inst_stall}, 32'h1);
    next_cycle();                                    // cycle 2: WAIT, data valid
    sram_rdata = 32'h2408_0001;
    settle();
    chk("f1_c2_en", {31'h0, sram_en}, 32'h0);
    chk("f1_c2_valid", {31'h0, inst_valid}, 32'h0);
    chk("f1_c2_stall", {31'h0, inst_stall}, 32'h1);
    next_cycle();                                    // cycle 3: DONE
    sram_rdata = 32'h5555_5555;
    settle();
    chk("f1_c3_valid", {31'h0, inst_valid}, 32'h1);
    chk("f1_c3_rdata", inst_rdata, 32'h2408_0001);
    chk("f1_c3_stall", {31'h0, inst_stall}, 32'h0);
    chk("f1_c3_dvalid", {31'h0, data_valid}, 32'h0);
    next_cycle();                                    // cycle 4: req dropped
    inst_req = 1'b0;
    settle();
    chk("f1_c4_valid", {31'h0, inst_valid}, 32'h0);
    chk("f1_c4_rdata_hold", inst_rdata, 32'h2408_0001);
    chk("f1_c4_en", {31'h0, sram_en}, 32'h0);

    // ---- contention: both rise together, data wins, then inst, then data ----
    next_cycle();                                    // cycle 0
    inst_req = 1'b1; inst_addr = 32'h0000_0100;
    data_req = 1'b1; data_addr = 32'h0000_0200; data_wen = 4'b0000;
    settle();
    next_cycle();                                    // cycle 1: data ISSUE
    settle();
    chk("ct_c1_en", {31'h0, sram_en}, 32'h1);
    chk("ct_c1_addr_data_first", sram_addr, 32'h0000_0200);
    next_cycle();                                    // cycle 2: WAIT
    sram_rdata = 32'hDA7A_0001;
    settle();
    next_cycle();                                    // cycle 3: data DONE
    sram_rdata = 32'h5555_5555;
    settle();
    chk("ct_c3_dvalid", {31'h0, data_valid}, 32'h1);
    chk("ct_c3_drdata", data_rdata, 32'hDA7A_0001);
    chk("ct_c3_ivalid", {31'h0, inst_valid}, 32'h0);
    chk("ct_c3_istall", {31'h0, inst_stall}, 32'h1);
    next_cycle();                                    // cycle 4: new data req held
    data_addr = 32'h0000_0300;
    settle();
    chk("ct_c4_dstall", {31'h0, data_stall}, 32'h1);
    next_cycle();                                    // cycle 5: inst ISSUE (prio)
    settle();
    chk("ct_c5_en", {31'h0, sram_en}, 32'h1);
    chk("ct_c5_addr_inst", sram_addr, 32'h0000_0100);
    next_cycle();                                    // cycle 6
    sram_rdata = 32'h1111_0000;
    settle();
    next_cycle();                                    // cycle 7: inst DONE
    sram_rdata = 32'h5555_5555;
    settle();
    chk("ct_c7_ivalid", {31'h0, inst_valid}, 32'h1);
    chk("ct_c7_irdata", inst_rdata, 32'h1111_0000);
    chk("ct_c7_dvalid", {31'h0, data_valid}, 32'h0);
    chk("ct_c7_drdata_hold", data_rdata, 32'hDA7A_0001);
    next_cycle();                                    // cycle 8: inst drops
    inst_req = 1'b0;
    settle();
    next_cycle();                                    // cycle 9: data ISSUE
    settle();
    chk("ct_c9_en", {31'h0, sram_en}, 32'h1);
    chk("ct_c9_addr", sram_addr, 32'h0000_0300);
    next_cycle();                                    // cycle 10
    sram_rdata = 32'h3333_0000;
    settle();
    next_cycle();                                    // cycle 11: data DONE
    sram_rdata = 32'h5555_5555;
    settle();
    chk("ct_c11_dvalid", {31'h0, data_valid}, 32'h1);
    chk("ct_c11_drdata", data_rdata, 32'h3333_0000);
    next_cycle();
    data_req = 1'b0;
    settle();

    // ---- partial store ----
    next_cycle();                                    // cycle 0
    data_req = 1'b1; data_wen = 4'b0011;
    data_addr = 32'h8000_0010; data_wdata = 32'h0000_BEEF;
    settle();
    chk("wr_c0_dstall", {31'h0, data_stall}, 32'h1);
    next_cycle();                                    // cycle 1: ISSUE
    settle();
    chk("wr_c1_en", {31'h0, sram_en}, 32'h1);
    chk("wr_c1_wen", {28'h0, sram_wen}, 32'h3);
    chk("wr_c1_addr", sram_addr, 32'h8000_0010);
    chk("wr_c1_wdata", sram_wdata, 32'h0000_BEEF);
    next_cycle();                                    // cycle 2: DONE
    settle();
    chk("wr_c2_dvalid", {31'h0, data_valid}, 32'h1);
    chk("wr_c2_drdata_zero", data_rdata, 32'h0);
    chk("wr_c2_en", {31'h0, sram_en}, 32'h0);
    chk("wr_c2_wen", {28'h0, sram_wen}, 32'h0);
    next_cycle();                                    // cycle 3
    data_req = 1'b0; data_wen = 4'b0000;
    settle();
    chk("wr_c3_dvalid", {31'h0, data_valid}, 32'h0);

    // ---- RD_LAT=3 data read ----
    next_cycle();                                    // cycle 0
    data_req3 = 1'b1; data_addr = 32'h0000_0040;
    settle();
    next_cycle();                                    // cycle 1: ISSUE
    sram_rdata = 32'h1111_1111;
    settle();
    chk("l3_c1_en", {31'h0, sram_en3}, 32'h1);
    chk("l3_c1_addr", sram_addr3, 32'h0000_0040);
    next_cycle();                                    // cycle 2: WAIT 1
    sram_rdata = 32'h2222_2222;
    settle();
    chk("l3_c2_en", {31'h0, sram_en3}, 32'h0);
    next_cycle();                                    // cycle 3: WAIT 2
    sram_rdata = 32'h3333_3333;
    settle();
    next_cycle();                                    // cycle 4: WAIT 3
    sram_rdata = 32'hCAFE_F00D;
    settle();
    chk("l3_c4_dvalid", {31'h0, data_valid3}, 32'h0);
    chk("l3_c4_dstall", {31'h0, data_stall3}, 32'h1);
    next_cycle();                                    // cycle 5: DONE
    sram_rdata = 32'h5555_5555;
    settle();
    chk("l3_c5_dvalid", {31'h0, data_valid3}, 32'h1);
    chk("l3_c5_drdata", data_rdata3, 32'hCAFE_F00D);
    next_cycle();
    data_req3 = 1'b0;
    settle();

    // ---- reset during WAIT, held request restarts ----
    next_cycle();                                    // cycle 0
    data_req3 = 1'b1; data_addr = 32'h0000_0044;
    settle();
    next_cycle();                                    // cycle 1: ISSUE
    settle();
    next_cycle();                                    // cycle 2: WAIT, reset
    rst = 1'b1;
    settle();
    next_cycle();                                    // cycle 3: IDLE
    rst = 1'b0;
    settle();
    chk("rw_c3_en", {31'h0, sram_en3}, 32'h0);
    chk("rw_c3_valids", {30'h0, inst_valid3, data_valid3}, 32'h0);
    chk("rw_c3_drdata3", data_rdata3, 32'h0);
    chk("rw_c3_rdata1", inst_rdata | data_rdata, 32'h0);
    next_cycle();                                    // cycle 4: ISSUE again
    settle();
    chk("rw_c4_en", {31'h0, sram_en3}, 32'h1);
    chk("rw_c4_addr", sram_addr3, 32'h0000_0044);
    next_cycle();                                    // cycle 5
    settle();
    next_cycle();                                    // cycle 6
    sram_rdata = 32'h6666_6666;
    settle();
    next_cycle();                                    // cycle 7
    sram_rdata = 32'h600D_F00D;
    settle();
    next_cycle();                                    // cycle 8: DONE
    sram_rdata = 32'h5555_5555;
    settle();
    chk("rw_c8_dvalid", {31'h0, data_valid3}, 32'h1);
    chk("rw_c8_drdata", data_rdata3, 32'h600D_F00D);
    next_cycle();
    data_req3 = 1'b0;
    settle();

    // ---- back-to-back fetches, req held across valid ----
    next_cycle();                                    // cycle 0
    inst_req = 1'b1; inst_addr = 32'h0000_1000; data_wen = 4'b1111;
    settle();
    next_cycle();                                    // cycle 1: ISSUE
    settle();
    chk("bb_c1_en", {31'h0, sram_en}, 32'h1);
    chk("bb_c1_wen_inst", {28'h0, sram_wen}, 32'h0);
    next_cycle();                                    // cycle 2
    sram_rdata = 32'hAAAA_0001;
    settle();
    next_cycle();                                    // cycle 3: DONE
    sram_rdata = 32'h5555_5555;
    settle();
    chk("bb_c3_ivalid", {31'h0, inst_valid}, 32'h1);
    chk("bb_c3_irdata", inst_rdata, 32'hAAAA_0001);
    next_cycle();                                    // cycle 4: new addr, IDLE
    inst_addr = 32'h0000_1004;
    settle();
    chk("bb_c4_en", {31'h0, sram_en}, 32'h0);
    chk("bb_c4_ivalid", {31'h0, inst_valid}, 32'h0);
    chk("bb_c4_istall", {31'h0, inst_stall}, 32'h1);
    next_cycle();                                    // cycle 5: second ISSUE
    settle();
    chk("bb_c5_en", {31'h0, sram_en}, 32'h1);
    chk("bb_c5_addr", sram_addr, 32'h0000_1004);
    next_cycle();                                    // cycle 6
    sram_rdata = 32'hAAAA_0002;
    settle();
    chk("bb_c6_en", {31'h0, sram_en}, 32'h0);
    next_cycle();                                    // cycle 7: DONE
    sram_rdata = 32'h5555_5555;
    settle();
    chk("bb_c7_ivalid", {31'h0, inst_valid}, 32'h1);
    chk("bb_c7_irdata", inst_rdata, 32'hAAAA_0002);
    next_cycle();                                    // cycle 8
    inst_req = 1'b0; data_wen = 4'b0000;
    settle();
    chk("bb_c8_en", {31'h0, sram_en}, 32'h0);
    next_cycle();
    settle();
    chk("bb_c9_en", {31'h0, sram_en}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Shares one single-port 32-bit data SRAM between the fetch-stage instruction requester and the memory-stage load/store requester.
- Sequences each access through issue, wait and acknowledge states with a configurable read latency.
- Produces per-requester stall signals that feed the hazard unit, so F/D freeze while fetch is pending and the whole pipe freezes while M is pending.

Parameters:
- RD_LAT, 1, SRAM read latency in cycles from the issue cycle to rdata valid; legal range 1..7.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- inst_req  input  1  fetch request; level, held until inst_valid
- inst_addr  input  32  fetch byte address, stable while inst_req
- inst_rdata  output  32  fetched word, valid with inst_valid
- inst_valid  output  1  one-cycle completion pulse for fetch
- inst_stall  output  1  inst_req & ~inst_valid
- data_req  input  1  load/store request; level, held until data_valid
- data_wen  input  4  byte write enables; 0 = read
- data_addr  input  32  data byte address
- data_wdata  input  32  store data
- data_rdata  output  32  load word, valid with data_valid
- data_valid  output  1  one-cycle completion pulse for data
- data_stall  output  1  data_req & ~data_valid
- sram_en  output  1  SRAM access strobe
- sram_wen  output  4  SRAM byte write enables
- sram_addr  output  32  SRAM byte address
- sram_wdata  output  32  SRAM write data
- sram_rdata  input  32  SRAM read data, RD_LAT cycles after the sram_en cycle

Behaviour:
- Reset: state=IDLE; all outputs 0, including sram_*, valids, rdata registers and cnt; prio_inst=0. A reset mid-access abandons that access, and sram_en=0 from the next cycle.
- FSM states are IDLE, ISSUE, WAIT and DONE.
- IDLE (sram_en=0) selects a requester:
  - If only one requester is active, select it.
  - If both are active, select data unless prio_inst=1.
  - Latch owner, addr, wen (0 for inst) and wdata into registers, then go to ISSUE. With no request, stay in IDLE.
- ISSUE (1 cycle): drive sram_en=1 and sram_wen/addr/wdata from the latched registers.
  - Read (wen==0): cnt<=RD_LAT, go to WAIT.
  - Write: go to DONE.
- WAIT: cnt decrements each cycle. When cnt==1, capture sram_rdata into the owner's rdata register and go to DONE. Total WAIT cycles = RD_LAT.
- DONE (1 cycle): pulse the owner's valid. The other requester's valid stays 0. Go to IDLE.
- Latency from req rising in IDLE to valid:
  - read: 2+RD_LAT cycles (3 at RD_LAT=1)
  - write: 2 cycles
- Throughput: one access per 3+RD_LAT cycles for reads, one per 3 cycles for writes.
- Handshake rules:
  - A requester holds req, addr, wen and wdata stable until its valid pulse.
  - A requester must drop req (or present a new request) in the cycle after valid; the IDLE cycle samples that value.
- Requests arriving during ISSUE, WAIT or DONE are not lost; they are served at the next IDLE.
- Fairness:
  - On a data grant while inst_req is active, set prio_inst=1.
  - On any inst grant, clear prio_inst.
  - Data is therefore never granted twice in a row while fetch waits.
- inst_rdata and data_rdata hold their last captured value until overwritten. A write sets data_rdata to 0 in DONE.
- sram_wen is always 0 for inst accesses, even if data_wen is nonzero.
- The arbiter does no address decoding or alignment; the lsmem logic has already aligned and byte-laned data_wdata/data_wen.

Test Plan:
- RD_LAT=1, inst_req at cycle 0 with addr 0xBFC00000 and sram_rdata=0x24080001 -> sram_en=1 with addr 0xBFC00000 at cycle 1; inst_valid=1 with rdata 0x24080001 at cycle 3; inst_stall=1 for cycles 0-2.
- data_req with wen=4'b0011, addr 0x80000010, wdata 0x0000BEEF -> sram_en=1, sram_wen=0011 and wdata 0x0000BEEF one cycle later; data_valid the following cycle (2 cycles after req).
- inst_req and data_req rise together (reads) -> data granted first with prio_inst=1; inst granted next; a third data_req raised during inst service is served after inst.
- RD_LAT=3, data read -> exactly 3 WAIT cycles; data_valid at req+5; data_rdata equals sram_rdata sampled 3 cycles after the sram_en cycle.
- rst asserted during WAIT -> next cycle: state IDLE, sram_en=0, both valids 0, rdata registers 0; a held req restarts cleanly from IDLE after rst drops.
- Back-to-back fetches with req held across valid (new addr presented) -> second ISSUE occurs 2 cycles after the first inst_valid, with no duplicate sram_en.
